// File: rtl/rr_mux_arbiter4_if.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter4_if
//   Bundles the requester, consumer and mux-control signals of the 4-way
//   round-robin arbiter into one interface.
//
//   Signals:
//     req        4  per-requester request, held high while beats remain
//     last       4  per-requester final-beat flag (only bit [sel] is used)
//     out_ready  1  downstream consumer accepts the current beat
//     sel        2  registered select for the shared mux2x4 path
//     grant      4  registered one-hot grant, zero when idle
//     out_valid  1  combinational beat-valid toward the consumer
//     busy       1  high while a grant is held
//
//   Modports:
//     master  the requesters/consumer side (drives req, last, out_ready)
//     slave   the arbiter side (drives sel, grant, out_valid, busy)
// ----------------------------------------------------------------------------
interface rr_mux_arbiter4_if;
    logic [3:0] req;
    logic [3:0] last;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       out_valid;
    logic       busy;

    modport master (
        output req,
        output last,
        output out_ready,
        input  sel,
        input  grant,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  req,
        input  last,
        input  out_ready,
        output sel,
        output grant,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/rr_mux_arbiter4.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter4
//   Round-robin arbiter that shares one 32-bit mux2x4 path among four
//   requesters. It picks a winner while idle, drives a registered mux select
//   and one-hot grant, and keeps the grant for a multi-beat transfer until the
//   requester signals its last beat, hits the MAX_HOLD beat limit, or drops
//   its request. Every release is followed by one idle cycle before the next
//   grant, and the rotation pointer moves past the released requester.
//
//   Parameters:
//     MAX_HOLD  maximum beats per grant before forced release (1..255)
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   rr_mux_arbiter4_if.slave
//             in : req[3:0], last[3:0], out_ready
//             out: sel[1:0], grant[3:0] (registered), out_valid (comb), busy
// ----------------------------------------------------------------------------
module rr_mux_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux_arbiter4_if.slave   bus
);

    // Beat counter width; sized to hold 0..MAX_HOLD.
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state;
    logic [1:0]      ptr;        // first requester examined at next arbitration
    logic [CW-1:0]   beat_cnt;   // beats completed under the current grant
    logic [1:0]      sel_r;
    logic [3:0]      grant_r;
    logic            busy_r;

    // ------------------------------------------------------------------------
    // Arbitration: first set request bit scanning ptr, ptr+1, ... (mod 4)
    // ------------------------------------------------------------------------
    logic [1:0] winner;
    logic       found;
    logic [1:0] idx;

    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Beat handshake and release decision for the granted requester
    // ------------------------------------------------------------------------
    logic cur_req;
    logic cur_last;
    logic out_valid;
    logic xfer;
    logic at_limit;
    logic release_now;

    assign cur_req   = bus.req[sel_r];
    assign cur_last  = bus.last[sel_r];
    assign out_valid = busy_r & cur_req;
    assign xfer      = out_valid & bus.out_ready;
    // Current beat is the MAX_HOLD-th one of this grant.
    assign at_limit  = (beat_cnt == CW'(MAX_HOLD - 1));
    // A withdrawn request aborts without a transfer; last/limit only count
    // on an accepted beat, and both together still form a single release.
    assign release_now = !cur_req | (xfer & (cur_last | at_limit));

    // ------------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            ptr      <= 2'd0;
            beat_cnt <= '0;
            sel_r    <= 2'd0;
            grant_r  <= 4'b0000;
            busy_r   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (found) begin
                        state    <= StGrant;
                        sel_r    <= winner;
                        grant_r  <= 4'b0001 << winner;
                        beat_cnt <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                StGrant: begin
                    if (release_now) begin
                        // sel keeps its last value; only grant/busy drop.
                        state   <= StIdle;
                        grant_r <= 4'b0000;
                        busy_r  <= 1'b0;
                        ptr     <= sel_r + 2'd1;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= StIdle;
                    grant_r <= 4'b0000;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.sel       = sel_r;
    assign bus.grant     = grant_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid;

endmodule
